// File: rtl/treeadder_feeder_pkg.sv
// Shared constants and types for the 8-lane tree-adder feeder and its
// latency tracker.
package treeadder_feeder_pkg;

  localparam int LANES     = 8;
  localparam int ADDER_LAT = 4;
  localparam int IDX_W     = $clog2(LANES);

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  // Bit offset of lane k inside a packed LANES*width bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/treeadder_feeder_if.sv
// Serial valid/ready word stream with an end-of-vector marker.
interface treeadder_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/treeadder_feeder_latency_tracker.sv
// Fixed-depth delay line of {valid, last} tags that shadows a free-running
// pipeline so side-band flags emerge aligned with its output.
module treeadder_feeder_latency_tracker
  import treeadder_feeder_pkg::*;
#(
  parameter int DEPTH = ADDER_LAT
) (
  input  logic clk,
  input  logic en,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t tag_p [DEPTH];

  // Stage 0 .. DEPTH-1: one tag per pipeline register of the shadowed datapath
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
    end else if (en) begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/treeadder_feeder.sv
// Packs a serial word stream into zero-padded 8-lane groups for the
// pipelined tree adder and flags when each group's sum reaches its output.
module treeadder_feeder
  import treeadder_feeder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  treeadder_feeder_if.slave      s,
  output logic [LANES*WIDTH-1:0] lanes_out,
  output logic                   issue,
  output logic                   adder_en,
  output logic                   adder_clr,
  output logic                   sum_valid,
  output logic                   sum_last,
  output logic [7:0]             grp_cnt
);

  logic                   flush;
  logic                   accept;
  logic                   close;
  logic [IDX_W-1:0]       lane_idx;
  logic [WIDTH-1:0]       pack_buf [LANES];
  logic [LANES*WIDTH-1:0] group_flat;
  logic                   issue_last;
  tag_t                   tag_in;
  tag_t                   tag_out;

  assign flush     = !rst_n || clr;
  assign s.s_ready = rst_n && !clr;
  assign adder_clr = clr;
  assign accept    = s.s_valid && s.s_ready;
  assign close     = accept && (s.s_last || lane_idx == IDX_W'(LANES - 1));

  // Slots above the closing word are forced to zero so a short final group
  // never carries words from an earlier group into the sum.
  always_comb begin
    group_flat = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(lane_idx))
        group_flat[lane_lsb(k, WIDTH) +: WIDTH] = pack_buf[k];
      else if (k == int'(lane_idx))
        group_flat[lane_lsb(k, WIDTH) +: WIDTH] = s.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) adder_en <= 1'b0;
    else        adder_en <= 1'b1;
  end

  // Pack stage: gather words, launch a group onto the lane bus on close
  always_ff @(posedge clk) begin
    if (flush) begin
      lanes_out  <= '0;
      issue      <= 1'b0;
      issue_last <= 1'b0;
      lane_idx   <= '0;
      grp_cnt    <= '0;
      for (int k = 0; k < LANES; k++) pack_buf[k] <= '0;
    end else begin
      issue      <= close;
      issue_last <= close && s.s_last;
      lanes_out  <= close ? group_flat : '0;

      if (accept) begin
        if (close) begin
          lane_idx <= '0;
          for (int k = 0; k < LANES; k++) pack_buf[k] <= '0;
        end else begin
          pack_buf[lane_idx] <= s.s_data;
          lane_idx           <= lane_idx + IDX_W'(1);
        end
      end

      // A vector's count is visible for one cycle after its last group,
      // then restarts; a group closing on that same edge counts as the first.
      if (issue && issue_last)
        grp_cnt <= close ? 8'd1 : 8'd0;
      else if (close && grp_cnt != 8'hFF)
        grp_cnt <= grp_cnt + 8'd1;
    end
  end

  assign tag_in = '{vld: issue, last: issue_last};

  // Adder stages 0..ADDER_LAT-1: tags ride alongside the adder's registers
  treeadder_feeder_latency_tracker #(
    .DEPTH (ADDER_LAT)
  ) u_latency_tracker (
    .clk     (clk),
    .en      (adder_en),
    .clr     (flush),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign sum_valid = tag_out.vld;
  assign sum_last  = tag_out.last;

endmodule

// File: tb/tb_treeadder_feeder.sv
// Directed bench for treeadder_feeder with a 4-stage reference tree adder
// attached to the lane bus.
module tb_treeadder_feeder;
  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [8*W-1:0] lanes_out;
  logic          issue;
  logic          adder_en;
  logic          adder_clr;
  logic          sum_valid;
  logic          sum_last;
  logic [7:0]    grp_cnt;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  treeadder_feeder_if #(.WIDTH(W)) sif ();

  treeadder_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .s         (sif),
    .lanes_out (lanes_out),
    .issue     (issue),
    .adder_en  (adder_en),
    .adder_clr (adder_clr),
    .sum_valid (sum_valid),
    .sum_last  (sum_last),
    .grp_cnt   (grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference adder: sum of 8 lanes, 4 register stages, wraps modulo 2^W
  function automatic logic [W-1:0] lane_sum(input logic [8*W-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + v[k*W +: W];
    return s;
  endfunction

  logic [W-1:0] add_p0 = '0, add_p1 = '0, add_p2 = '0, add_p3 = '0;
  always @(posedge clk) begin
    if (adder_clr || !rst_n) begin
      add_p0 <= '0; add_p1 <= '0; add_p2 <= '0; add_p3 <= '0;
    end else if (adder_en) begin
      add_p0 <= lane_sum(lanes_out);
      add_p1 <= add_p0;
      add_p2 <= add_p1;
      add_p3 <= add_p2;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic [8*W-1:0] iss_lanes_q[$];
  int             iss_cyc_q[$];
  logic [7:0]     iss_cnt_q[$];
  logic [W-1:0]   sum_q[$];
  logic           sum_last_q[$];
  int             sum_cyc_q[$];

  always @(negedge clk) begin
    if (issue === 1'b1) begin
      iss_lanes_q.push_back(lanes_out);
      iss_cyc_q.push_back(cyc);
      iss_cnt_q.push_back(grp_cnt);
    end
    if (sum_valid === 1'b1) begin
      sum_q.push_back(add_p3);
      sum_last_q.push_back(sum_last);
      sum_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_mon();
    iss_lanes_q.delete(); iss_cyc_q.delete(); iss_cnt_q.delete();
    sum_q.delete(); sum_last_q.delete(); sum_cyc_q.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    sif.s_data = d; sif.s_valid = 1'b1; sif.s_last = last;
    @(posedge clk); #1;
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    idle(3);
    checks++; if (lanes_out !== '0) $display("FAIL rst_lanes got=%0h exp=0", lanes_out); else passed++;
    checks++; if (issue !== 1'b0) $display("FAIL rst_issue got=%b exp=0", issue); else passed++;
    checks++; if (adder_en !== 1'b0) $display("FAIL rst_adder_en got=%b exp=0", adder_en); else passed++;
    checks++; if (sum_valid !== 1'b0) $display("FAIL rst_sum_valid got=%b exp=0", sum_valid); else passed++;
    checks++; if (sum_last !== 1'b0) $display("FAIL rst_sum_last got=%b exp=0", sum_last); else passed++;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL rst_grp_cnt got=%0d exp=0", grp_cnt); else passed++;
    checks++; if (sif.s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b exp=0", sif.s_ready); else passed++;
    rst_n = 1'b1; #1;
    checks++; if (sif.s_ready !== 1'b1) $display("FAIL rel_s_ready got=%b exp=1", sif.s_ready); else passed++;
    idle(1);
    checks++; if (adder_en !== 1'b1) $display("FAIL rel_adder_en got=%b exp=1", adder_en); else passed++;
    idle(5);
  endtask

  task automatic test_full_vector();
    clear_mon();
    for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
    idle(8);
    checks++; if (iss_lanes_q.size() !== 1) $display("FAIL full_issues got=%0d exp=1", iss_lanes_q.size()); else passed++;
    checks++; if (iss_lanes_q[0] !== 128'h0008_0007_0006_0005_0004_0003_0002_0001)
      $display("FAIL full_lanes got=%h exp=00080007000600050004000300020001", iss_lanes_q[0]); else passed++;
    checks++; if (iss_cnt_q[0] !== 8'd1) $display("FAIL full_grp_cnt got=%0d exp=1", iss_cnt_q[0]); else passed++;
    checks++; if (sum_q.size() !== 1) $display("FAIL full_sums got=%0d exp=1", sum_q.size()); else passed++;
    checks++; if (sum_q[0] !== 16'd36) $display("FAIL full_sum got=%0d exp=36", sum_q[0]); else passed++;
    checks++; if (sum_last_q[0] !== 1'b1) $display("FAIL full_sum_last got=%b exp=1", sum_last_q[0]); else passed++;
    checks++; if (sum_cyc_q[0] - iss_cyc_q[0] !== 4) $display("FAIL full_latency got=%0d exp=4", sum_cyc_q[0] - iss_cyc_q[0]); else passed++;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL full_grp_cnt_after got=%0d exp=0", grp_cnt); else passed++;
  endtask

  task automatic test_partial_with_gap();
    clear_mon();
    send(16'd5, 1'b0);
    idle(3);
    send(16'd6, 1'b0);
    send(16'd7, 1'b1);
    idle(8);
    checks++; if (iss_lanes_q.size() !== 1) $display("FAIL part_issues got=%0d exp=1", iss_lanes_q.size()); else passed++;
    checks++; if (iss_lanes_q[0] !== 128'h0000_0000_0000_0000_0000_0007_0006_0005)
      $display("FAIL part_lanes got=%h exp=00000000000000000000000700060005", iss_lanes_q[0]); else passed++;
    checks++; if (sum_q[0] !== 16'd18) $display("FAIL part_sum got=%0d exp=18", sum_q[0]); else passed++;
    checks++; if (sum_last_q[0] !== 1'b1) $display("FAIL part_sum_last got=%b exp=1", sum_last_q[0]); else passed++;
    checks++; if (iss_cnt_q[0] !== 8'd1) $display("FAIL part_grp_cnt got=%0d exp=1", iss_cnt_q[0]); else passed++;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL part_grp_cnt_after got=%0d exp=0", grp_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_sum  [3] = '{16'd8, 16'd8, 16'd4};
    logic         exp_last [3] = '{1'b0, 1'b0, 1'b1};
    clear_mon();
    for (int i = 1; i <= 20; i++) send(16'h0001, i == 20);
    idle(8);
    checks++; if (iss_lanes_q.size() !== 3) $display("FAIL b2b_issues got=%0d exp=3", iss_lanes_q.size()); else passed++;
    checks++; if (sum_q.size() !== 3) $display("FAIL b2b_sums got=%0d exp=3", sum_q.size()); else passed++;
    for (int g = 0; g < 3; g++) begin
      checks++; if (sum_q[g] !== exp_sum[g]) $display("FAIL b2b_sum%0d got=%0d exp=%0d", g, sum_q[g], exp_sum[g]); else passed++;
      checks++; if (sum_last_q[g] !== exp_last[g]) $display("FAIL b2b_last%0d got=%b exp=%b", g, sum_last_q[g], exp_last[g]); else passed++;
      checks++; if (iss_cnt_q[g] !== 8'(g + 1)) $display("FAIL b2b_cnt%0d got=%0d exp=%0d", g, iss_cnt_q[g], g + 1); else passed++;
    end
    checks++; if (iss_lanes_q[2] !== 128'h0000_0000_0000_0000_0001_0001_0001_0001)
      $display("FAIL b2b_lanes2 got=%h exp=00000000000000000001000100010001", iss_lanes_q[2]); else passed++;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL b2b_grp_cnt_after got=%0d exp=0", grp_cnt); else passed++;

    // Two single-word vectors on consecutive cycles
    clear_mon();
    send(16'd9, 1'b1);
    send(16'd10, 1'b1);
    idle(8);
    checks++; if (iss_cyc_q.size() !== 2) $display("FAIL pair_issues got=%0d exp=2", iss_cyc_q.size()); else passed++;
    checks++; if (iss_cyc_q[1] - iss_cyc_q[0] !== 1) $display("FAIL pair_issue_gap got=%0d exp=1", iss_cyc_q[1] - iss_cyc_q[0]); else passed++;
    checks++; if (sum_q[0] !== 16'd9) $display("FAIL pair_sum0 got=%0d exp=9", sum_q[0]); else passed++;
    checks++; if (sum_q[1] !== 16'd10) $display("FAIL pair_sum1 got=%0d exp=10", sum_q[1]); else passed++;
    checks++; if (sum_cyc_q[1] - sum_cyc_q[0] !== 1) $display("FAIL pair_sum_gap got=%0d exp=1", sum_cyc_q[1] - sum_cyc_q[0]); else passed++;
    checks++; if (iss_cnt_q[1] !== 8'd1) $display("FAIL pair_cnt1 got=%0d exp=1", iss_cnt_q[1]); else passed++;
  endtask

  task automatic test_wrap();
    clear_mon();
    for (int i = 1; i <= 16; i++) send(16'h8000, i == 16);
    idle(8);
    checks++; if (sum_q.size() !== 2) $display("FAIL wrap_sums got=%0d exp=2", sum_q.size()); else passed++;
    checks++; if (sum_q[0] !== 16'h0000) $display("FAIL wrap_sum0 got=%h exp=0000", sum_q[0]); else passed++;
    checks++; if (sum_q[1] !== 16'h0000) $display("FAIL wrap_sum1 got=%h exp=0000", sum_q[1]); else passed++;
    checks++; if (sum_last_q[0] !== 1'b0) $display("FAIL wrap_last0 got=%b exp=0", sum_last_q[0]); else passed++;
    checks++; if (sum_last_q[1] !== 1'b1) $display("FAIL wrap_last1 got=%b exp=1", sum_last_q[1]); else passed++;
    checks++; if (iss_lanes_q[0] !== {8{16'h8000}}) $display("FAIL wrap_lanes got=%h exp=all 8000", iss_lanes_q[0]); else passed++;
  endtask

  task automatic test_clr();
    clear_mon();
    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    checks++; if (issue !== 1'b1) $display("FAIL clr_issue got=%b exp=1", issue); else passed++;
    idle(1);
    clr = 1'b1; sif.s_valid = 1'b1; sif.s_data = 16'hAAAA; sif.s_last = 1'b0;
    #1;
    checks++; if (sif.s_ready !== 1'b0) $display("FAIL clr_s_ready got=%b exp=0", sif.s_ready); else passed++;
    checks++; if (adder_clr !== 1'b1) $display("FAIL clr_adder_clr got=%b exp=1", adder_clr); else passed++;
    @(posedge clk); #1;
    clr = 1'b0; sif.s_valid = 1'b0;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL clr_grp_cnt got=%0d exp=0", grp_cnt); else passed++;
    checks++; if (adder_en !== 1'b1) $display("FAIL clr_adder_en got=%b exp=1", adder_en); else passed++;
    idle(8);
    checks++; if (sum_q.size() !== 0) $display("FAIL clr_no_sum got=%0d exp=0", sum_q.size()); else passed++;
    checks++; if (iss_lanes_q.size() !== 1) $display("FAIL clr_issues got=%0d exp=1", iss_lanes_q.size()); else passed++;
    clear_mon();
    send(16'd3, 1'b0);
    send(16'd4, 1'b1);
    idle(8);
    checks++; if (iss_lanes_q[0] !== 128'h0000_0000_0000_0000_0000_0000_0004_0003)
      $display("FAIL clr_next_lanes got=%h exp=00000000000000000000000000040003", iss_lanes_q[0]); else passed++;
    checks++; if (sum_q[0] !== 16'd7) $display("FAIL clr_next_sum got=%0d exp=7", sum_q[0]); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int i = 1; i <= 5; i++) send(16'(i), 1'b0);
    rst_n = 1'b0;
    idle(1);
    checks++; if (lanes_out !== '0) $display("FAIL mid_lanes got=%h exp=0", lanes_out); else passed++;
    checks++; if (issue !== 1'b0) $display("FAIL mid_issue got=%b exp=0", issue); else passed++;
    checks++; if (adder_en !== 1'b0) $display("FAIL mid_adder_en got=%b exp=0", adder_en); else passed++;
    checks++; if (sum_valid !== 1'b0) $display("FAIL mid_sum_valid got=%b exp=0", sum_valid); else passed++;
    checks++; if (grp_cnt !== 8'd0) $display("FAIL mid_grp_cnt got=%0d exp=0", grp_cnt); else passed++;
    checks++; if (sif.s_ready !== 1'b0) $display("FAIL mid_s_ready got=%b exp=0", sif.s_ready); else passed++;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
    idle(8);
    checks++; if (iss_lanes_q.size() !== 1) $display("FAIL mid_issues got=%0d exp=1", iss_lanes_q.size()); else passed++;
    checks++; if (iss_lanes_q[0] !== 128'h0008_0007_0006_0005_0004_0003_0002_0001)
      $display("FAIL mid_lanes_next got=%h exp=00080007000600050004000300020001", iss_lanes_q[0]); else passed++;
    checks++; if (sum_q[0] !== 16'd36) $display("FAIL mid_sum got=%0d exp=36", sum_q[0]); else passed++;
    checks++; if (sum_cyc_q[0] - iss_cyc_q[0] !== 4) $display("FAIL mid_latency got=%0d exp=4", sum_cyc_q[0] - iss_cyc_q[0]); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    sif.s_data = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    test_reset();
    test_full_vector();
    test_partial_with_gap();
    test_back_to_back();
    test_wrap();
    test_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
